spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
Serial front end that sits directly upstream of the single-port SPI RAM. Deserialises MOSI frames into 10-bit words {cmd[1:0], payload[7:0]} and hands each word to the RAM on rx_data/rx_valid. For read-data transactions it accepts the RAM's tx_data/tx_valid response and serialises it MSB-first on MISO. SPI sampling runs on the system clock: one MOSI bit per clk while SS_n is low.

Parameters:
ADDR_SIZE, 8, payload/address width; rx_data width is ADDR_SIZE+2, tx_data width is ADDR_SIZE.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  reset, asynchronous, active-low.
SS_n  in  1  slave select, active-low; frames a transaction.
MOSI  in  1  serial data in, sampled on posedge clk.
MISO  out  1  serial data out, changes on posedge clk.
rx_data  out  ADDR_SIZE+2  received word, MSB first on the wire; [ADDR_SIZE+1:ADDR_SIZE] = cmd.
rx_valid  out  1  one-cycle strobe: rx_data holds a complete word.
tx_data  in  ADDR_SIZE  read data from RAM.
tx_valid  in  1  tx_data valid; captured only while awaiting read data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, MISO=0, rx_valid=0, rx_data=0, bit counter=0, rd_addr_received=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 sampled -> CHK_CMD; else stay.
- CHK_CMD: sample MOSI as selector (not stored). 0 -> WRITE. 1 -> READ_DATA if rd_addr_received=1, else READ_ADD.
- WRITE/READ_ADD/READ_DATA: shift MOSI into a 10-bit shift register, MSB first, 10 cycles. In the cycle after the 10th bit: rx_data <= shifted word, rx_valid=1 for exactly one clk.
- rx_data holds its value until the next completed word. The word is forwarded unchanged; the selector bit is not checked against cmd.
- After the word: READ_ADD sets rd_addr_received=1. READ_DATA clears it.
- WRITE/READ_ADD post-word: ignore MOSI and stay until SS_n=1. One word per frame.
- READ_DATA post-word: wait for tx_valid=1 (no timeout). On that cycle latch tx_data. MISO drives bits [7]..[0] on the next 8 consecutive cycles, one per clk. MISO then returns to 0 and the block holds until SS_n=1.
- tx_valid outside the READ_DATA wait window is ignored.
- SS_n=1 sampled in any non-IDLE state -> IDLE next cycle. Effects: bit counter cleared, partial word discarded, no rx_valid, MISO=0, serialisation aborted. rd_addr_received is unchanged unless the read-data word had already completed.
- rd_addr_received persists across frames and is cleared only by reset or a completed READ_DATA word.
- MISO=0 whenever not actively serialising.
- Reset mid-frame: immediate return to reset values, including rd_addr_received=0.

Decomposition:
- Shared package (the existing RAM shared package, extended):
  - ADDR_SIZE and the cmd codes WRITE_ADD=2'b00, WRITE_DATA=2'b01, READ_ADD=2'b10, READ_DATA=2'b11.
  - ACTIVE_RESET/INACTIVE constants.
  - State enum spi_state_e {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA}.
- One sub-module: spi_tx_shifter (load on tx_valid capture, 8-bit MSB-first shift, done flag).

Test Plan:
- Reset: hold rst_n=0 mid-frame -> MISO=0, rx_valid=0, rx_data=0, state IDLE immediately, without waiting for a clk edge.
- Write address: SS_n falls, sampled at cycle k; MOSI=0 at k+1, then 10'b00_1010_0101 at k+2..k+11 -> rx_valid=1 only at k+12, rx_data=10'h0A5.
- Read sequence:
  - Frame 1: selector 1 + 10'b10_0011_0011 -> rx_data=10'h233, rd_addr_received=1.
  - Frame 2: selector 1 + 10'b11_0000_0000 -> READ_DATA path, rx_data=10'h300.
  - Drive tx_valid=1, tx_data=8'hC3 two cycles later -> MISO=1,1,0,0,0,0,1,1 on the following 8 cycles, then 0.
- Abort: SS_n rises after 5 of 10 bits in WRITE -> no rx_valid, IDLE next cycle; next full frame yields the correct word.
- Ordering: read frame while rd_addr_received=0 -> READ_ADD path; tx_valid pulse during WRITE ignored, MISO stays 0.
- Post-word noise: 6 extra MOSI toggles after a WRITE word with SS_n low -> no second rx_valid, rx_data unchanged.

Source files
------------

// File: rtl/spi_slave_if_pkg.sv
// Shared definitions for the SPI RAM slice: address width, command codes,
// reset levels and the SPI front-end state encoding.
package spi_slave_if_pkg;

  localparam int unsigned ADDR_SIZE = 8;

  // Command codes carried in rx_data[ADDR_SIZE+1:ADDR_SIZE]
  localparam logic [1:0] CMD_WRITE_ADD  = 2'b00;
  localparam logic [1:0] CMD_WRITE_DATA = 2'b01;
  localparam logic [1:0] CMD_READ_ADD   = 2'b10;
  localparam logic [1:0] CMD_READ_DATA  = 2'b11;

  localparam logic ACTIVE_RESET = 1'b0;
  localparam logic INACTIVE     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser for RAM read data; MISO is registered
// and held at 0 whenever no bits are being driven.
module spi_tx_shifter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  output logic             miso_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic [Width-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             miso_q, miso_d;
  logic             done_q, done_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    miso_d = 1'b0;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load_i) begin
      sreg_d = data_i;
      cnt_d  = CntW'(Width);
      done_d = 1'b0;
    end else if (cnt_q != '0) begin
      miso_d = sreg_q[Width-1];
      sreg_d = {sreg_q[Width-2:0], 1'b0};
      cnt_d  = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      miso_q <= miso_d;
      done_q <= done_d;
    end
  end

  assign miso_o = miso_q;
  assign busy_o = (cnt_q != '0);
  assign done_o = done_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises one {cmd, payload} word per frame for the
// RAM and, on read-data frames, serialises the RAM response back on MISO.
module spi_slave_if #(
  parameter int unsigned ADDR_SIZE = spi_slave_if_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  import spi_slave_if_pkg::*;

  localparam int unsigned WordW = ADDR_SIZE + 2;
  localparam int unsigned CntW  = $clog2(WordW + 1);

  spi_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WordW-1:0] shift_q, shift_d;
  logic [WordW-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rd_addr_received_q, rd_addr_received_d;
  logic             word_done_q, word_done_d;
  logic             tx_load, tx_busy, tx_done;

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    shift_d            = shift_q;
    rx_data_d          = rx_data_q;
    rx_valid_d         = 1'b0;
    rd_addr_received_d = rd_addr_received_q;
    word_done_d        = word_done_q;
    tx_load            = 1'b0;
    if (state_q != IDLE && SS_n == INACTIVE) begin
      // Frame end or abort: any partial word is dropped.
      state_d     = IDLE;
      cnt_d       = '0;
      word_done_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          cnt_d       = '0;
          word_done_d = 1'b0;
          if (!MOSI)                   state_d = WRITE;
          else if (rd_addr_received_q) state_d = READ_DATA;
          else                         state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!word_done_q) begin
            if (cnt_q != CntW'(WordW)) begin
              shift_d = {shift_q[WordW-2:0], MOSI};
              cnt_d   = cnt_q + CntW'(1);
            end else begin
              rx_data_d   = shift_q;
              rx_valid_d  = 1'b1;
              word_done_d = 1'b1;
              cnt_d       = '0;
              if (state_q == READ_ADD)       rd_addr_received_d = 1'b1;
              else if (state_q == READ_DATA) rd_addr_received_d = 1'b0;
            end
          end else if (state_q == READ_DATA) begin
            // Single capture per frame; later tx_valid pulses are ignored.
            tx_load = tx_valid && !tx_busy && !tx_done;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      shift_q            <= '0;
      rx_data_q          <= '0;
      rx_valid_q         <= 1'b0;
      rd_addr_received_q <= 1'b0;
      word_done_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      shift_q            <= shift_d;
      rx_data_q          <= rx_data_d;
      rx_valid_q         <= rx_valid_d;
      rd_addr_received_q <= rd_addr_received_d;
      word_done_q        <= word_done_d;
    end
  end

  spi_tx_shifter #(
    .Width (ADDR_SIZE)
  ) u_tx_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (SS_n),
    .load_i (tx_load),
    .data_i (tx_data),
    .miso_o (MISO),
    .busy_o (tx_busy),
    .done_o (tx_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised frame-level bench for spi_slave_if against a transaction model
// of the SPI frame timing.
module tb_spi_slave_if;

  localparam int AW    = 8;
  localparam int EmitE = AW + 4;  // edge index (from SS_n sampled low) of rx_valid

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SS_n = 1'b1;
  logic          MOSI = 1'b0;
  logic          tx_valid = 1'b0;
  logic [AW-1:0] tx_data = '0;
  logic          MISO;
  logic          rx_valid;
  logic [AW+1:0] rx_data;

  int unsigned   nvec = 0;
  int unsigned   nerr = 0;

  bit            rd_flag = 1'b0;
  logic [AW+1:0] last_rx = '0;

  always #5 clk = ~clk;

  spi_slave_if #(
    .ADDR_SIZE (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string ctx, input logic exp_miso, input logic exp_valid);
    check_eq({ctx, ".miso"}, 32'(MISO), 32'(exp_miso));
    check_eq({ctx, ".rx_valid"}, 32'(rx_valid), 32'(exp_valid));
    check_eq({ctx, ".rx_data"}, 32'(rx_data), 32'(last_rx));
  endtask

  // One frame: edge 0 samples SS_n low, edge 1 the selector, edges 2..EmitE-1
  // the word; SS_n is sampled high at end_edge. tx_byte is offered at tx_edge
  // on read-data frames. rst_edge >= 0 asserts reset just after that edge.
  task automatic run_frame(input bit sel, input logic [AW+1:0] word, input int end_edge,
                           input int tx_edge, input logic [AW-1:0] tx_byte, input int rst_edge);
    bit            rd_path;
    bit            rd_add;
    int            cap;
    logic [AW-1:0] cap_byte;
    logic          exp_miso, exp_valid;
    rd_path  = sel && rd_flag;
    rd_add   = sel && !rd_flag;
    cap      = -1;
    cap_byte = '0;
    for (int e = 0; e <= end_edge; e++) begin
      SS_n = (e == end_edge);
      if (e == 1)                   MOSI = sel;
      else if (e >= 2 && e < EmitE) MOSI = word[AW+3-e];
      else                          MOSI = 1'($urandom);
      if (rd_path && e == tx_edge) begin
        tx_valid = 1'b1;
        tx_data  = tx_byte;
      end else begin
        tx_data  = AW'($urandom);
        tx_valid = ($urandom_range(3) == 0) && !(rd_path && e > EmitE && e <= tx_edge);
      end
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      if (e != end_edge) begin
        if (e == EmitE) begin
          exp_valid = 1'b1;
          last_rx   = word;
          if (rd_add)       rd_flag = 1'b1;
          else if (rd_path) rd_flag = 1'b0;
        end
        if (rd_path && cap < 0 && e > EmitE && tx_valid) begin
          cap      = e;
          cap_byte = tx_data;
        end
      end
      exp_miso = 1'b0;
      if (e != end_edge && cap >= 0 && e > cap && e <= cap + AW) exp_miso = cap_byte[cap+AW-e];
      check_outs("frame", exp_miso, exp_valid);
      if (e == rst_edge) begin
        #2 rst_n = 1'b0;
        #1;
        rd_flag = 1'b0;
        last_rx = '0;
        check_outs("async_rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("rst_hold", 1'b0, 1'b0);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        return;
      end
    end
    tx_valid = 1'b0;
    for (int g = 0; g < int'($urandom_range(2)); g++) begin
      @(posedge clk);
      #1;
      check_outs("gap", 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1;
    check_outs("reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("idle", 1'b0, 1'b0);

    run_frame(1'b0, 10'h0A5, EmitE + 2, -1, 8'h00, -1);
    run_frame(1'b1, 10'h233, EmitE + 2, -1, 8'h00, -1);
    run_frame(1'b1, 10'h300, EmitE + 2 + AW + 3, EmitE + 2, 8'hC3, -1);
    run_frame(1'b0, 10'h3FF, 7, -1, 8'h00, -1);
    run_frame(1'b0, 10'h155, EmitE + 1, -1, 8'h00, -1);
    run_frame(1'b1, 10'h2AA, EmitE + 4, EmitE + 2, 8'hFF, -1);
    run_frame(1'b0, 10'h04C, EmitE + 7, -1, 8'h00, -1);
    run_frame(1'b1, 10'h3C3, EmitE + 20, EmitE + 2, 8'hA5, EmitE + 5);
    run_frame(1'b1, 10'h211, EmitE + 2, -1, 8'h00, -1);
    run_frame(1'b1, 10'h35A, EmitE + 2 + AW + 2, EmitE + 2, 8'h96, -1);

    for (int n = 0; n < 40; n++) begin
      bit            sel;
      logic [AW+1:0] word;
      int            tx_e;
      int            end_e;
      sel   = 1'($urandom);
      word  = (AW+2)'($urandom);
      tx_e  = EmitE + int'($urandom_range(4, 2));
      if ($urandom_range(3) == 0)          end_e = int'($urandom_range(EmitE, 1));
      else if (sel && rd_flag)             end_e = tx_e + int'($urandom_range(AW + 4, 1));
      else                                 end_e = EmitE + 1 + int'($urandom_range(6));
      run_frame(sel, word, end_e, tx_e, AW'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
